// File: rtl/sync_fifo_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | sync_fifo_flags: single-clock FIFO with occupancy count, almost flags   |
// | and overflow/underflow pulses. Define SYNC_FIFO_FWFT_EN for FWFT reads. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module sync_fifo_flags #(
  parameter int WIDTH     = 8,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         din,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         dout,
  output logic                     valid,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic             w_wr_ok;
  logic             w_rd_ok;
  logic [CW-1:0]    w_count_nxt;

  assign w_wr_ok = wr_en && !full;
  assign w_rd_ok = rd_en && !empty;

  always_comb begin
    w_count_nxt = count;
    case ({w_wr_ok, w_rd_ok})
      2'b10:   w_count_nxt = count + 1'b1;
      2'b01:   w_count_nxt = count - 1'b1;
      default: w_count_nxt = count;
    endcase
  end

  // Flags come from the next count so they line up with the count register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr     <= '0;
      r_rd_ptr     <= '0;
      count        <= '0;
      full         <= 1'b0;
      empty        <= 1'b1;
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      if (w_wr_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_ok) r_rd_ptr <= r_rd_ptr + 1'b1;
      count        <= w_count_nxt;
      full         <= (w_count_nxt == CW'(DEPTH));
      empty        <= (w_count_nxt == '0);
      almost_full  <= (w_count_nxt >= CW'(AF_THRESH));
      almost_empty <= (w_count_nxt <= CW'(AE_THRESH));
      overflow     <= wr_en && full;
      underflow    <= rd_en && empty;
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_ok) r_mem[r_wr_ptr] <= din;
  end

`ifdef SYNC_FIFO_FWFT_EN
  assign dout  = r_mem[r_rd_ptr];
  assign valid = !empty;
`else
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dout  <= '0;
      valid <= 1'b0;
    end else begin
      if (w_rd_ok) dout <= r_mem[r_rd_ptr];
      valid <= w_rd_ok;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_sync_fifo_flags.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_sync_fifo_flags: directed bench for sync_fifo_flags (DEPTH=16).       |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_sync_fifo_flags;

  localparam int WIDTH = 8;
  localparam int DEPTH = 16;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             wr_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             valid;
  logic             full;
  logic             empty;
  logic             almost_full;
  logic             almost_empty;
  logic [4:0]       count;
  logic             overflow;
  logic             underflow;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] mq [$];
  logic [7:0] exp_q [$];
  logic [7:0] last_rd = 8'h00;
  logic       exp_ovf = 1'b0;
  logic       exp_unf = 1'b0;
  logic       exp_vld = 1'b0;

  sync_fifo_flags #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .din(din), .rd_en(rd_en),
    .dout(dout), .valid(valid), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty), .count(count),
    .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Read-data monitor: pops the scoreboard whenever the DUT presents a word.
  initial begin
    forever begin
      @(negedge clk);
`ifdef SYNC_FIFO_FWFT_EN
      if (!rst && valid && rd_en) begin
        if (mq.size() == 0) chk("sb_underrun", 1, 0);
        else chk("fwft_dout", int'(dout), int'(mq[0]));
      end
`else
      if (!rst && valid) begin
        if (exp_q.size() == 0) chk("sb_underrun", 1, 0);
        else chk("rd_dout", int'(dout), int'(exp_q.pop_front()));
      end
`endif
    end
  end

  task automatic check_flags();
    int n;
    n = mq.size();
    chk("count", int'(count), n);
    chk("full", int'(full), int'(n == DEPTH));
    chk("empty", int'(empty), int'(n == 0));
    chk("almost_full", int'(almost_full), int'(n >= DEPTH - 2));
    chk("almost_empty", int'(almost_empty), int'(n <= 2));
    chk("overflow", int'(overflow), int'(exp_ovf));
    chk("underflow", int'(underflow), int'(exp_unf));
`ifdef SYNC_FIFO_FWFT_EN
    chk("valid", int'(valid), int'(n != 0));
`else
    chk("valid", int'(valid), int'(exp_vld));
    chk("dout_hold", int'(dout), int'(last_rd));
`endif
  endtask

  task automatic step(input logic we, input logic [7:0] d, input logic re);
    logic acc_w, acc_r;
    wr_en = we; din = d; rd_en = re;
    @(posedge clk);
    acc_w = we && (mq.size() < DEPTH);
    acc_r = re && (mq.size() > 0);
    if (acc_r) begin
      last_rd = mq.pop_front();
      exp_q.push_back(last_rd);
    end
    if (acc_w) mq.push_back(d);
    exp_ovf = we && !acc_w;
    exp_unf = re && !acc_r;
    exp_vld = acc_r;
    #1;
    wr_en = 1'b0; rd_en = 1'b0;
    check_flags();
  endtask

  initial begin
    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_count", int'(count), 0);
    chk("rst_empty", int'(empty), 1);
    chk("rst_ae", int'(almost_empty), 1);
    chk("rst_full", int'(full), 0);
    chk("rst_af", int'(almost_full), 0);
    chk("rst_valid", int'(valid), 0);
    chk("rst_ovf", int'(overflow), 0);
    chk("rst_unf", int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("rst_dout", int'(dout), 0);
`endif

    // Fill 0x01..0x10
    for (int i = 1; i <= 16; i++) begin
      step(1'b1, 8'(i), 1'b0);
      if (i == 13) chk("af_at_13", int'(almost_full), 0);
      if (i == 14) chk("af_at_14", int'(almost_full), 1);
    end
    chk("full_16", int'(full), 1);
    chk("count_16", int'(count), 16);
    step(1'b1, 8'hFF, 1'b0);
    chk("ovf_pulse", int'(overflow), 1);
    chk("ovf_count", int'(count), 16);
    step(1'b0, 8'h00, 1'b0);
    chk("ovf_clear", int'(overflow), 0);

    // Drain
    for (int i = 1; i <= 16; i++) step(1'b0, 8'h00, 1'b1);
    chk("drain_empty", int'(empty), 1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("drain_last", int'(dout), 8'h10);
`endif

    // Underflow on empty
    step(1'b0, 8'h00, 1'b1);
    chk("unf_pulse", int'(underflow), 1);
    chk("unf_valid", int'(valid), 0);
    chk("unf_count", int'(count), 0);
    step(1'b0, 8'h00, 1'b0);
    chk("unf_clear", int'(underflow), 0);

    // Simultaneous access at count 5
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h20 + i), 1'b0);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 8'hAA, 1'b1);
      chk("sim_count5", int'(count), 5);
    end
    for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous when full
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h30 + i), 1'b0);
    step(1'b1, 8'h77, 1'b1);
    chk("simfull_count", int'(count), 15);
    chk("simfull_ovf", int'(overflow), 1);
    for (int i = 0; i < 15; i++) step(1'b0, 8'h00, 1'b1);

    // Simultaneous when empty
    step(1'b1, 8'h55, 1'b1);
    chk("simempty_count", int'(count), 1);
    chk("simempty_unf", int'(underflow), 1);
    step(1'b0, 8'h00, 1'b1);

    // Wrap-around 12/12/12/12
    for (int i = 0; i < 12; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
    for (int i = 12; i < 24; i++) step(1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("wrap_last", int'(dout), 8'h17);
`endif

    // Asynchronous reset between edges at count 7
    for (int i = 0; i < 7; i++) step(1'b1, 8'(8'h60 + i), 1'b0);
    chk("pre_rst_count", int'(count), 7);
    #2 rst = 1'b1;
    #1;
    chk("arst_count", int'(count), 0);
    chk("arst_empty", int'(empty), 1);
    chk("arst_ae", int'(almost_empty), 1);
    chk("arst_full", int'(full), 0);
    chk("arst_af", int'(almost_full), 0);
    chk("arst_valid", int'(valid), 0);
    chk("arst_ovf", int'(overflow), 0);
    chk("arst_unf", int'(underflow), 0);
`ifndef SYNC_FIFO_FWFT_EN
    chk("arst_dout", int'(dout), 0);
`endif
    mq.delete();
    exp_q.delete();
    last_rd = 8'h00; exp_ovf = 1'b0; exp_unf = 1'b0; exp_vld = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    step(1'b1, 8'h5A, 1'b0);
`ifdef SYNC_FIFO_FWFT_EN
    chk("fwft_5a_dout", int'(dout), 8'h5A);
    chk("fwft_5a_valid", int'(valid), 1);
`endif
    step(1'b0, 8'h00, 1'b1);
`ifndef SYNC_FIFO_FWFT_EN
    chk("post_rst_dout", int'(dout), 8'h5A);
    chk("post_rst_valid", int'(valid), 1);
`endif
    step(1'b0, 8'h00, 1'b0);
    chk("sb_drained", exp_q.size() == 0 || !valid ? int'(exp_q.size()) : -1, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
